// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways) with LRU replacement, word-by-word
// block fill over the iREN/iwait handshake, flush, and saturating hit/miss counters.
module icache_assoc #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  input  logic             flush,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned WOB    = $clog2(BLOCK_WORDS);
  localparam int unsigned WOW    = (WOB > 0) ? WOB : 1;
  localparam int unsigned IW     = $clog2(SETS);
  localparam int unsigned TW     = 30 - WOB - IW;
  localparam int unsigned IDX_SH = 2 + WOB;
  localparam int unsigned TAG_SH = 2 + WOB + IW;
  localparam int unsigned LAST   = BLOCK_WORDS - 1;

  typedef enum logic {S_IDLE, S_FILL} state_e;

  state_e             state_q;
  logic [SETS-1:0]    valid_q [WAYS];
  logic [TW-1:0]      tag_q   [WAYS][SETS];
  logic [31:0]        data_q  [WAYS][SETS][BLOCK_WORDS];
  logic [SETS-1:0]    lru_q;
  logic [TW-1:0]      ftag_q;
  logic [IW-1:0]      fidx_q;
  logic [WOW-1:0]     cnt_q;
  logic [31:0]        buf_q [BLOCK_WORDS];
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   miss_cnt_q;

  logic [TW-1:0]      req_tag;
  logic [IW-1:0]      req_idx;
  logic [WOW-1:0]     req_wo;
  logic [1:0]         way_hit;
  logic               lookup_hit;
  logic               hit_way;
  logic               victim;
  logic               word_acc;
  logic               fill_done;

  // Address decomposition of the incoming fetch
  always_comb begin
    req_tag = TW'(imemaddr >> TAG_SH);
    req_idx = IW'(imemaddr >> IDX_SH);
    req_wo  = (WOB > 0) ? WOW'(imemaddr >> 2) : '0;
  end

  // Tag compare across ways; way 0 wins if both somehow match
  always_comb begin
    way_hit = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
    end
    lookup_hit = |way_hit;
    hit_way    = (WAYS == 2) && !way_hit[0];
    ihit       = imemREN && (state_q == S_IDLE) && !flush && lookup_hit;
    imemload   = ihit ? data_q[hit_way][req_idx][req_wo] : 32'd0;
  end

  // Replacement choice for the set being filled: free way first, else LRU
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!valid_q[0][fidx_q]) begin
        victim = 1'b0;
      end else if (!valid_q[WAYS-1][fidx_q]) begin
        victim = 1'b1;
      end else begin
        victim = lru_q[fidx_q];
      end
    end
  end

  always_comb begin
    word_acc  = (state_q == S_FILL) && !iwait && !flush && !RST;
    fill_done = word_acc && (cnt_q == WOW'(LAST));
    iREN      = (state_q == S_FILL);
    iaddr     = 32'd0;
    if (state_q == S_FILL) begin
      iaddr = (32'(ftag_q) << TAG_SH) | (32'(fidx_q) << IDX_SH);
      if (WOB > 0) begin
        iaddr = iaddr | (32'(cnt_q) << 2);
      end
    end
    hit_count  = hit_cnt_q;
    miss_count = miss_cnt_q;
  end

  // Control state: FSM, valid/tag/LRU, counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
      end
      lru_q      <= '0;
      ftag_q     <= '0;
      fidx_q     <= '0;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ihit) begin
        if (WAYS == 2) begin
          lru_q[req_idx] <= ~hit_way;
        end
        if (hit_cnt_q != {CNT_W{1'b1}}) begin
          hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
      end
      if (flush) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[w] <= '0;
        end
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (imemREN && !lookup_hit) begin
              ftag_q  <= req_tag;
              fidx_q  <= req_idx;
              cnt_q   <= '0;
              state_q <= S_FILL;
            end
          end
          S_FILL: begin
            if (!iwait) begin
              if (cnt_q == WOW'(LAST)) begin
                valid_q[victim][fidx_q] <= 1'b1;
                tag_q[victim][fidx_q]   <= ftag_q;
                if (WAYS == 2) begin
                  lru_q[fidx_q] <= ~victim;
                end
                if (miss_cnt_q != {CNT_W{1'b1}}) begin
                  miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                end
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                cnt_q <= cnt_q + WOW'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Fill buffer and data arrays carry no reset; the last word goes straight from iload
  always_ff @(posedge CLK) begin
    if (word_acc) begin
      buf_q[cnt_q] <= iload;
    end
    if (fill_done) begin
      for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
        data_q[victim][fidx_q][k] <= (k == LAST) ? iload : buf_q[k];
      end
    end
  end

endmodule
